mmr_register_writer: RTL

- Writer/holder side of the K-modular-redundant register path: stores one N-bit value in K_MMR independent replica registers and drives all replicas out for downstream voting.
- Votes its own replicas internally and periodically scrubs (rewrites all replicas with the voted value) so single-replica upsets do not accumulate.
- Sits inside the MMR register bank, one instance per protected control/status register, ahead of the voter arrays on the read path.

---
 rtl/mmr_register_writer.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/mmr_register_writer.sv
// rtl/mmr_register_writer.sv - K-replica register with internal majority vote, periodic scrub and repair counting
module mmr_register_writer #(
    parameter int              K_MMR        = 3,
    parameter int              N            = 16,
    parameter logic [N-1:0]    RESET_VALUE  = '0,
    parameter int              SCRUB_PERIOD = 256,
    parameter int              CNT_W        = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 wr_en_i,
    input  logic [N-1:0]         wr_data_i,
    output logic                 wr_ready_o,
    input  logic                 scrub_en_i,
    input  logic                 fault_inj_en_i,
    input  logic [K_MMR*N-1:0]   fault_mask_i,
    output logic [K_MMR*N-1:0]   replica_o,
    output logic [N-1:0]         voted_o,
    output logic                 mismatch_o,
    output logic                 scrub_busy_o,
    output logic [CNT_W-1:0]     err_cnt_o,
    input  logic                 err_cnt_clr_i
);

    localparam int TW = $clog2(SCRUB_PERIOD);
    localparam int CW = $clog2(K_MMR + 1);

    typedef enum logic [1:0] {IDLE, COUNT, CHECK, REPAIR} state_t;

    state_t               state_q;
    logic [TW-1:0]        timer_q;
    logic [K_MMR*N-1:0]   replica_q;
    logic [CNT_W-1:0]     err_cnt_q;
    logic                 mismatch_q;
    logic                 busy_q;
    logic                 ready_q;
    logic [N-1:0]         voted;
    logic                 disagree;
    logic [CW-1:0]        ones;

    // Strict majority per bit: an even-K tie resolves to 0.
    always_comb begin
        voted = '0;
        ones  = '0;
        for (int b = 0; b < N; b++) begin
            ones = '0;
            for (int k = 0; k < K_MMR; k++) begin
                ones = ones + CW'(replica_q[k*N + b]);
            end
            voted[b] = (ones > CW'(K_MMR / 2));
        end
    end

    always_comb begin
        disagree = 1'b0;
        for (int k = 0; k < K_MMR; k++) begin
            if (replica_q[k*N +: N] != voted) begin
                disagree = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            replica_q  <= {K_MMR{RESET_VALUE}};
            err_cnt_q  <= '0;
            mismatch_q <= 1'b0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            mismatch_q <= disagree;

            // Replica update priority: repair, then accepted write, then injection.
            if (state_q == REPAIR) begin
                replica_q <= {K_MMR{voted}};
            end else if (wr_en_i && ready_q) begin
                replica_q <= {K_MMR{wr_data_i}};
            end else if (fault_inj_en_i) begin
                replica_q <= replica_q ^ fault_mask_i;
            end

            if (state_q == REPAIR) begin
                if (err_cnt_clr_i) begin
                    err_cnt_q <= CNT_W'(1);
                end else if (err_cnt_q != '1) begin
                    err_cnt_q <= err_cnt_q + CNT_W'(1);
                end
            end else if (err_cnt_clr_i) begin
                err_cnt_q <= '0;
            end

            if (!scrub_en_i) begin
                state_q <= IDLE;
                timer_q <= '0;
                busy_q  <= 1'b0;
                ready_q <= 1'b1;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q <= COUNT;
                        timer_q <= '0;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end
                    COUNT: begin
                        if (timer_q == TW'(SCRUB_PERIOD - 1)) begin
                            timer_q <= '0;
                            state_q <= CHECK;
                            busy_q  <= 1'b1;
                        end else begin
                            timer_q <= timer_q + TW'(1);
                        end
                    end
                    CHECK: begin
                        if (disagree) begin
                            state_q <= REPAIR;
                            busy_q  <= 1'b1;
                            ready_q <= 1'b0;
                        end else begin
                            state_q <= COUNT;
                            busy_q  <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= COUNT;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign replica_o    = replica_q;
    assign voted_o      = voted;
    assign mismatch_o   = mismatch_q;
    assign scrub_busy_o = busy_q;
    assign wr_ready_o   = ready_q;
    assign err_cnt_o    = err_cnt_q;

endmodule
